fhg_tx_pkt_fifo: RTL
====================

Name: fhg_tx_pkt_fifo

Overview:
- Store-and-forward packet FIFO between the CASPER 1024-bit AXI-Stream TX source and fhg_axis_adapter.
- Releases a packet to the adapter only after its last beat has been accepted and committed. The adapter therefore never sees a mid-packet gap, which the DCMAC segmented TX cannot tolerate.
- Drops errored packets (tuser), oversize packets and packets that hit a full FIFO, instead of back-pressuring CASPER.

Parameters:
- DATA_WIDTH, 1024, tdata width (bits).
- KEEP_WIDTH, 128, tkeep width; equals DATA_WIDTH/8.
- ADDR_WIDTH, 7, RAM address width; capacity 2^ADDR_WIDTH-1 = 127 beats.
- MAX_PKT_BEATS, 64, maximum legal packet length in beats (8192 B / 128 B).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  CASPER TX data.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tuser  in  1  packet error flag; sampled on any beat.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  data to adapter.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables to adapter.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  last beat to adapter.
- m_axis_tuser  out  1  always 0; bad packets never leave the block.
- m_axis_tready  in  1  adapter ready.
- drop_pulse  out  1  one-cycle pulse per dropped packet.
- pkt_cnt  out  32  packets committed (wraps).
- drop_cnt  out  32  packets dropped (wraps).

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, drop_pulse=0, pkt_cnt=0, drop_cnt=0. All pointers=0; writer state IDLE.
- A reset asserted mid-packet discards all stored and partial packets; nothing is emitted afterwards.
- s_axis_tready=1 in every cycle after the first post-reset cycle. The block never back-pressures the source; overflow causes a drop.
- Pointers are ADDR_WIDTH bits and wrap modulo 2^ADDR_WIDTH. Write side keeps wr_ptr (speculative) and wr_commit; read side keeps rd_ptr.
- full = (wr_ptr+1 == rd_ptr), with rd_ptr as registered in the current cycle.
- Writer FSM (accepted beat = tvalid & tready):
  - IDLE: on a beat go to WRITE, or DROP if that beat is already bad; write the beat and set beat_cnt=1. A single-beat packet (tlast in IDLE) is handled as in WRITE.
  - WRITE: write each beat to RAM[wr_ptr], wr_ptr++, beat_cnt++.
  - Bad beat: tuser=1, or full, or beat_cnt would exceed MAX_PKT_BEATS. On a bad beat: wr_ptr <= wr_commit, do not write. If that beat has tlast, go to IDLE and pulse drop; otherwise go to DROP.
  - Good tlast beat: write it; wr_commit <= wr_ptr+1; go to IDLE; pkt_cnt++.
  - DROP: discard every beat. On tlast go to IDLE, pulse drop_pulse, drop_cnt++. Exactly one drop is counted per packet.
- RAM width is DATA_WIDTH+KEEP_WIDTH+1 (data, keep, last), with registered read.
- Read side:
  - One-beat read latency plus an output register, with a prefetch/skid so a fully committed packet streams back-to-back at 1 beat/clk while m_axis_tready=1.
  - A committed beat becomes visible on m_axis no earlier than 2 cycles and no later than 3 cycles after its tlast is accepted.
  - Standard AXIS: while tvalid & !tready, tdata/tkeep/tlast are held stable. tvalid never drops mid-packet, because the whole packet is committed.
  - rd_ptr never passes wr_commit.
- Same-cycle write commit and read are allowed. A full buffer with simultaneous read still uses the registered rd_ptr, so the beat is dropped (conservative).
- Counters wrap 2^32-1 -> 0.

Optional Feature:
- Macro: FHG_PKT_FIFO_KEEP_CHECK_EN.
- With the macro defined:
  - Non-last beats must have tkeep all ones.
  - Last beats must have contiguous tkeep from bit 0, with at least bit 0 set.
  - Any violation marks the packet bad (same path as tuser).
- Without the macro, tkeep is passed through unchecked.

Test Plan:
- Two 64-beat packets, tdata = incrementing 1..128, m_tready=1 -> two packets out, 64 beats each, data 1..64 and 65..128, tlast on beats 64 and 128, pkt_cnt=2, no gaps within a packet.
- 64-beat packet with tuser=1 on beat 10, then a good 64-beat packet -> only the second appears; drop_cnt=1, one drop_pulse, first output beat equals the second packet's beat 1.
- m_tready=0 while three 64-beat packets arrive -> packet 1 committed, packet 2 fills the buffer at beat 64 (127-beat capacity) and is dropped, packet 3 dropped; then m_tready=1 -> exactly 64 beats out, drop_cnt=2.
- 65-beat packet -> dropped at beat 65; no output; drop_cnt=1, pkt_cnt=0.
- m_tready toggled 1/0 every cycle on a 64-beat packet -> data stays stable during stalls, and all 64 beats are delivered in order.
- Reset asserted at beat 30 of a packet, then a new 64-beat packet -> only the new packet appears; counters restart from 0.

Source files
------------

// File: rtl/fhg_tx_pkt_fifo.sv
// fhg_tx_pkt_fifo: store-and-forward TX packet FIFO; drops errored, oversize and overflowing packets.
// Define FHG_PKT_FIFO_KEEP_CHECK_EN to also reject packets with malformed tkeep.
module fhg_tx_pkt_fifo #(
    parameter int DATA_WIDTH    = 1024,
    parameter int KEEP_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 7,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  drop_pulse,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt
);
    localparam int RW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int CW = $clog2(MAX_PKT_BEATS + 2);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, DROP = 2'd2;

    logic [RW-1:0]         mem [0:(2**ADDR_WIDTH)-1];
    logic [RW-1:0]         ram_q;
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_commit, wr_nxt, rd_ptr, rd_addr;
    logic [CW-1:0]         beat_cnt, next_cnt;
    logic                  acc, full, keep_bad, bad, wr_en, rd_en, s1_valid, s1_moves;

`ifdef FHG_PKT_FIFO_KEEP_CHECK_EN
    assign keep_bad = s_axis_tlast
        ? (!s_axis_tkeep[0] || ((s_axis_tkeep + KEEP_WIDTH'(1)) & s_axis_tkeep) != '0)
        : (s_axis_tkeep != '1);
`else
    assign keep_bad = 1'b0;
`endif

    assign m_axis_tuser = 1'b0;
    assign acc      = s_axis_tvalid & s_axis_tready;
    assign wr_nxt   = wr_ptr + ADDR_WIDTH'(1);
    assign next_cnt = (state == IDLE) ? CW'(1) : beat_cnt + CW'(1);
    // rd_ptr only advances on output handshakes, so prefetched beats still occupy space
    assign full     = wr_nxt == rd_ptr;
    assign bad      = s_axis_tuser | full | (next_cnt > CW'(MAX_PKT_BEATS)) | keep_bad;
    assign wr_en    = acc & (state != DROP) & !bad;
    assign s1_moves = !m_axis_tvalid | m_axis_tready;
    assign rd_en    = (rd_addr != wr_commit) & (!s1_valid | s1_moves);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        if (rd_en) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            beat_cnt      <= '0;
            s_axis_tready <= 1'b0;
            drop_pulse    <= 1'b0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            drop_pulse    <= 1'b0;
            if (acc) begin
                if (state == DROP || bad) begin
                    if (state != DROP) wr_ptr <= wr_commit;
                    if (s_axis_tlast) begin
                        state      <= IDLE;
                        drop_pulse <= 1'b1;
                        drop_cnt   <= drop_cnt + 32'd1;
                    end else begin
                        state <= DROP;
                    end
                end else begin
                    wr_ptr   <= wr_nxt;
                    beat_cnt <= next_cnt;
                    state    <= s_axis_tlast ? IDLE : WRITE;
                    if (s_axis_tlast) begin
                        wr_commit <= wr_nxt;
                        pkt_cnt   <= pkt_cnt + 32'd1;
                    end
                end
            end
        end
    end

    // RAM output register acts as the skid stage behind the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            rd_addr       <= '0;
            s1_valid      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) rd_addr <= rd_addr + ADDR_WIDTH'(1);
            s1_valid <= rd_en | (s1_valid & !s1_moves);
            if (m_axis_tvalid & m_axis_tready) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (s1_moves) begin
                m_axis_tvalid <= s1_valid;
                if (s1_valid) {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= ram_q;
            end
        end
    end
endmodule
